psu_pchinfo_rx: RTL

- Receive end of the patch-information stream produced by the patch information unit; front-end of the PSU.
- Accepts per-patch pchinfo beats framed by topsu_valid and last_pchinfo, and applies backpressure through the producer's reg_stall.
- Buffers whole instructions, then presents each one downstream as a descriptor (opcode, touched-patch mask, beat count), followed by a valid/ready beat stream.
- No cut-through: an instruction is visible downstream only after its last beat is stored.

---
 rtl/psu_pchinfo_rx_pkg.sv | 36 +++
 rtl/psu_rx_fifo.sv | 53 +++++
 rtl/psu_pchinfo_rx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/psu_pchinfo_rx_pkg.sv
// Shared definitions for the PSU pchinfo receive front-end.
// Beat and patch geometry, output FSM encoding, descriptor layout, and a
// patch-index to one-hot mask helper.
package psu_pchinfo_rx_pkg;

  localparam int NUM_PCH    = 20;
  localparam int PCHADDR_BW = 5;
  localparam int OPCODE_BW  = 4;
  localparam int PCHINFO_BW = 64;
  localparam int PCHIDX_LSB = 20;
  localparam int NBEATS_BW  = PCHADDR_BW + 1;
  localparam int DESC_BW    = OPCODE_BW + NUM_PCH + NBEATS_BW;

  typedef enum logic [1:0] {
    PSURX_IDLE   = 2'd0,
    PSURX_HEAD   = 2'd1,
    PSURX_STREAM = 2'd2
  } psurx_state_e;

  typedef struct packed {
    logic [OPCODE_BW-1:0] opcode;
    logic [NUM_PCH-1:0]   mask;
    logic [NBEATS_BW-1:0] nbeats;
  } psurx_desc_t;

  // Out-of-range indices map to an empty mask.
  function automatic logic [NUM_PCH-1:0] pch_onehot(input logic [PCHADDR_BW-1:0] idx);
    logic [NUM_PCH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_PCH; i++) begin
      if (idx == PCHADDR_BW'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/psu_rx_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata (head, show-ahead),
// empty, count (entries in use, 0..DEPTH).
// Push while full and pop while empty are ignored.
module psu_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psu_pchinfo_rx.sv
// PSU front-end: receives pchinfo beats, buffers whole instructions, then
// presents each as a descriptor followed by its beat stream.
// Ports: clk, rst (async, active-high); producer side pchinfo_in, opcode_in,
// topsu_valid_in, last_pchinfo_in, stall_out; descriptor side inst_valid/
// inst_ready/inst_opcode/inst_mask/inst_nbeats; beat side beat_valid/
// beat_ready/beat_data/beat_last; err_out (sticky protocol error).
module psu_pchinfo_rx
  import psu_pchinfo_rx_pkg::*;
#(
  parameter int BEAT_DEPTH = 32,
  parameter int INST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PCHINFO_BW-1:0] pchinfo_in,
  input  logic [OPCODE_BW-1:0]  opcode_in,
  input  logic                  topsu_valid_in,
  input  logic                  last_pchinfo_in,
  output logic                  stall_out,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [OPCODE_BW-1:0]  inst_opcode,
  output logic [NUM_PCH-1:0]    inst_mask,
  output logic [NBEATS_BW-1:0]  inst_nbeats,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [PCHINFO_BW-1:0] beat_data,
  output logic                  beat_last,
  output logic                  err_out
);

  localparam int BAW = $clog2(BEAT_DEPTH);
  localparam int IAW = $clog2(INST_DEPTH);

  logic [PCHADDR_BW-1:0] pchidx;
  logic                  idx_bad;
  logic                  push, overflow, beat_push, desc_push;
  logic [NBEATS_BW-1:0]  inflight;
  logic [NUM_PCH-1:0]    acc_mask;
  logic                  err_q;
  psurx_desc_t           desc_in, desc_head;
  logic [PCHINFO_BW-1:0] beat_head;
  logic                  beat_empty, desc_empty;
  logic [BAW:0]          beat_count;
  logic [IAW:0]          desc_count;
  logic                  inst_pop, beat_pop;
  psurx_state_e          state_q, state_d;
  logic [NBEATS_BW-1:0]  rem_q;

  assign pchidx  = pchinfo_in[PCHIDX_LSB +: PCHADDR_BW];
  assign idx_bad = (pchidx >= PCHADDR_BW'(NUM_PCH));

  // One spare beat entry absorbs the beat already sitting in the producer's
  // output register when stall_out rises.
  assign stall_out = rst | (beat_count >= (BAW+1)'(BEAT_DEPTH-1))
                   | (desc_count == (IAW+1)'(INST_DEPTH));

  assign push      = topsu_valid_in & ~stall_out;
  assign overflow  = push & ~last_pchinfo_in & (inflight == NBEATS_BW'(NUM_PCH-1));
  assign beat_push = push & ~overflow;
  assign desc_push = beat_push & last_pchinfo_in;

  always_comb begin
    desc_in        = '0;
    desc_in.opcode = opcode_in;
    desc_in.mask   = acc_mask | pch_onehot(pchidx);
    desc_in.nbeats = inflight + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      acc_mask <= '0;
      err_q    <= 1'b0;
    end else begin
      if (desc_push) begin
        inflight <= '0;
        acc_mask <= '0;
      end else if (beat_push) begin
        inflight <= inflight + 1'b1;
        acc_mask <= acc_mask | pch_onehot(pchidx);
      end
      if (overflow || (beat_push && idx_bad)) err_q <= 1'b1;
    end
  end

  assign err_out = err_q;

  psu_rx_fifo #(.WIDTH(PCHINFO_BW), .DEPTH(BEAT_DEPTH)) u_beat_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (beat_push),
    .wdata (pchinfo_in),
    .pop   (beat_pop),
    .rdata (beat_head),
    .empty (beat_empty),
    .count (beat_count)
  );

  psu_rx_fifo #(.WIDTH(DESC_BW), .DEPTH(INST_DEPTH)) u_desc_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (desc_push),
    .wdata (desc_in),
    .pop   (inst_pop),
    .rdata (desc_head),
    .empty (desc_empty),
    .count (desc_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PSURX_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (inst_pop)      rem_q <= desc_head.nbeats;
      else if (beat_pop) rem_q <= rem_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PSURX_IDLE:   if (!desc_empty) state_d = PSURX_HEAD;
      PSURX_HEAD:   if (inst_ready) state_d = PSURX_STREAM;
      PSURX_STREAM: if (beat_pop && beat_last) state_d = PSURX_IDLE;
      default:      state_d = PSURX_IDLE;
    endcase
  end

  // Payload outputs are forced to zero outside their valid window.
  always_comb begin
    inst_valid  = (state_q == PSURX_HEAD);
    beat_valid  = (state_q == PSURX_STREAM) & ~beat_empty;
    beat_last   = beat_valid & (rem_q == NBEATS_BW'(1));
    inst_pop    = inst_valid & inst_ready;
    beat_pop    = beat_valid & beat_ready;
    inst_opcode = inst_valid ? desc_head.opcode : '0;
    inst_mask   = inst_valid ? desc_head.mask   : '0;
    inst_nbeats = inst_valid ? desc_head.nbeats : '0;
    beat_data   = beat_valid ? beat_head        : '0;
  end

endmodule
